rv_mem_arb3: RTL and testbench

- Round-robin arbiter that shares one 64-bit memory/bus port between three requesters: A = fetch, B = load/store, C = debug.
- Drives the 2-bit select of the downstream 3-input 64-bit mux (00→A, 01→B, 10→C) and sequences one transaction at a time: issue, then wait for response.
- Sits between the core's memory clients and the single data-memory port.

---
 rtl/rv_arb_pkg.sv | 24 ++
 rtl/rv_rr_pick3.sv | 29 ++
 rtl/rv_mem_arb3.sv | 136 +++++++++++++
 tb/tb_rv_mem_arb3.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_arb_pkg.sv
// Shared types and helpers for the three-way memory port arbiter.
package rv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } arb_state_e;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;

  // Map a requester index (0=A, 1=B, 2=C) onto the downstream mux select.
  // Anything out of range falls back to C so 2'b11 is never produced.
  function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    return SEL_A;
      2'd1:    return SEL_B;
      default: return SEL_C;
    endcase
  endfunction

endpackage

// File: rtl/rv_rr_pick3.sv
// Combinational round-robin picker for three requesters.
// Scans from (last+1) mod 3 upward with wrap and returns the first set bit.
module rv_rr_pick3
  import rv_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt_idx,
  output logic       any
);

  logic [1:0] start;

  // First requester after the previous winner, wrapping C back to A.
  always_comb begin
    start   = (last >= 2'd2) ? 2'd0 : last + 2'd1;
    gnt_idx = 2'd0;
    any     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      int k;
      k = (int'(start) + i) % 3;
      if (!any && req[k]) begin
        any     = 1'b1;
        gnt_idx = 2'(k);
      end
    end
  end

endmodule

// File: rtl/rv_mem_arb3.sv
// Round-robin arbiter sharing one memory port between fetch (A),
// load/store (B) and debug (C). One transaction at a time:
// IDLE -> ISSUE (mem_valid until mem_ready) -> WAIT (until mem_rsp_valid).
// Optional feature: define RV_ARB_TIMEOUT_EN to bound WAIT at
// TIMEOUT_CYCLES and return an error response on expiry.
module rv_mem_arb3
  import rv_arb_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_valid,
  input  logic [2:0] req_we,
  output logic [2:0] req_ready,
  output logic [1:0] mux_sel,
  output logic       mem_valid,
  input  logic       mem_ready,
  input  logic       mem_rsp_valid,
  output logic [2:0] rsp_valid,
  output logic       rsp_err,
  output logic       busy
);

  if (XLEN < 1) begin : g_bad_xlen
    $error("rv_mem_arb3: XLEN must be positive");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("rv_mem_arb3: TIMEOUT_CYCLES must be positive");
  end

  // Write enables only steer the external mux; reads and writes are
  // sequenced identically here.
  logic unused_req_we;
  assign unused_req_we = ^req_we;

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] pick_idx;
  logic       pick_any;

`ifdef RV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  rv_rr_pick3 u_pick (
    .req     (req_valid),
    .last    (last_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign mux_sel = sel_q;
  assign busy    = (state_q != IDLE);

  // Next-state and handshake outputs; all pulses are combinational per state.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    sel_d     = sel_q;
    mem_valid = 1'b0;
    req_ready = 3'b000;
    rsp_valid = 3'b000;
    rsp_err   = 1'b0;
`ifdef RV_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          sel_d   = idx_to_sel(pick_idx);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          req_ready = 3'b001 << grant_q;
          last_d    = grant_q;
          state_d   = WAIT;
`ifdef RV_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      WAIT: begin
        // A real response always beats a coincident timeout.
        if (mem_rsp_valid) begin
          rsp_valid = 3'b001 << grant_q;
          state_d   = IDLE;
        end
`ifdef RV_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          rsp_valid = 3'b001 << grant_q;
          rsp_err   = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset leaves A with first priority and drops any
  // in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      last_q  <= 2'd2;
      sel_q   <= SEL_A;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

`ifdef RV_ARB_TIMEOUT_EN
  // WAIT-cycle counter for the response timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_rv_mem_arb3.sv
// Scoreboard bench for rv_mem_arb3: stimulus pushes expected grants and
// responses, a monitor pops and compares whenever the DUT pulses.
module tb_rv_mem_arb3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req_valid;
  logic [2:0] req_we;
  logic [2:0] req_ready;
  logic [1:0] mux_sel;
  logic       mem_valid;
  logic       mem_ready;
  logic       mem_rsp_valid;
  logic [2:0] rsp_valid;
  logic       rsp_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // expected {mux_sel, req_ready} and {rsp_err, rsp_valid}
  logic [4:0] exp_rdy[$];
  logic [3:0] exp_rsp[$];
  int         rdy_times[$];
  int         rdy_cnt = 0;
  int         pending = 0;
  int         cyc = 0;
  int         stall_cycles = 0;

  // memory model controls
  int   stall_left = 0;
  logic resp_due = 1'b0;
  logic rsp_en = 1'b1;
  logic stray = 1'b0;

  rv_mem_arb3 #(.XLEN(64), .TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_ready     (req_ready),
    .mux_sel       (mux_sel),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .rsp_valid     (rsp_valid),
    .rsp_err       (rsp_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory responder: accepts after stall_left cycles, answers one cycle later.
  initial begin
    mem_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_rsp_valid = (resp_due && rsp_en) || stray;
      resp_due = 1'b0;
      if (mem_valid) begin
        if (stall_left > 0) begin
          mem_ready = 1'b0;
          stall_left--;
        end else begin
          mem_ready = 1'b1;
          resp_due = 1'b1;
        end
      end else begin
        mem_ready = 1'b0;
      end
    end
  end

  // Monitor: compares every req_ready / rsp_valid pulse against the queues.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (mem_valid && !mem_ready) stall_cycles++;
        if (req_ready != 3'b000) begin
          if (exp_rdy.size() == 0) check("unexpected_req_ready", {27'd0, mux_sel, req_ready}, 32'd0);
          else check("req_ready_sel", {27'd0, mux_sel, req_ready}, {27'd0, exp_rdy.pop_front()});
          rdy_times.push_back(cyc);
          rdy_cnt++;
          pending++;
        end
        if (rsp_valid != 3'b000) begin
          check("rsp_after_accept", pending, 1);
          pending = 0;
          if (exp_rsp.size() == 0) check("unexpected_rsp", {28'd0, rsp_err, rsp_valid}, 32'd0);
          else check("rsp_valid_err", {28'd0, rsp_err, rsp_valid}, {28'd0, exp_rsp.pop_front()});
        end
      end
    end
  end

  task automatic wait_rdy(input int target);
    int b = 0;
    while (rdy_cnt < target && b < 200) begin
      tick();
      b++;
    end
    check("wait_ready_bound", (rdy_cnt >= target), 1);
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((exp_rdy.size() != 0 || exp_rsp.size() != 0 || busy) && b < 200) begin
      tick();
      b++;
    end
    check("wait_idle_bound", (b < 200), 1);
  endtask

  // one single-requester transaction: index, stall cycles
  task automatic single(input int idx, input int stall);
    logic [2:0] bit_v;
    bit_v = 3'b001 << idx;
    exp_rdy.push_back({2'(idx), bit_v});
    exp_rsp.push_back({1'b0, bit_v});
    stall_left = stall;
    req_valid = bit_v;
    wait_rdy(rdy_cnt + 1);
    req_valid = 3'b000;
    wait_idle();
  endtask

  initial begin
    int base;
    rst_n = 1'b1;
    req_valid = 3'b000;
    req_we = 3'b000;
    #3 rst_n = 1'b0;
    #1;
    check("rst_mux_sel", mux_sel, 2'b00);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // fairness: all three held, zero-wait memory
    base = rdy_cnt;
    exp_rdy.push_back({2'b00, 3'b001}); exp_rsp.push_back({1'b0, 3'b001});
    exp_rdy.push_back({2'b01, 3'b010}); exp_rsp.push_back({1'b0, 3'b010});
    exp_rdy.push_back({2'b10, 3'b100}); exp_rsp.push_back({1'b0, 3'b100});
    exp_rdy.push_back({2'b00, 3'b001}); exp_rsp.push_back({1'b0, 3'b001});
    req_valid = 3'b111;
    req_we = 3'b010;
    wait_rdy(base + 4);
    req_valid = 3'b000;
    wait_idle();
    for (int i = 1; i < 4; i++)
      check("fair_spacing", rdy_times[base + i] - rdy_times[base + i - 1], 3);

    // wrap: make C the last winner, then B and C request -> B wins
    single(2, 0);
    exp_rdy.push_back({2'b01, 3'b010});
    exp_rsp.push_back({1'b0, 3'b010});
    req_valid = 3'b110;
    wait_rdy(rdy_cnt + 1);
    req_valid = 3'b000;
    wait_idle();

    // stall: A with five not-ready cycles
    stall_cycles = 0;
    single(0, 5);
    check("stall_cycles", stall_cycles, 5);

    // stray response while idle
    stray = 1'b1;
    tick();
    tick();
    stray = 1'b0;
    tick();
    check("stray_busy", busy, 0);

    // reset in the middle of ISSUE for C
    stall_left = 1000;
    req_valid = 3'b100;
    tick();
    check("mid_issue_mem_valid", mem_valid, 1);
    check("mid_issue_sel", mux_sel, 2'b10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_valid", mem_valid, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_mux_sel", mux_sel, 2'b00);
    check("mid_rst_busy", busy, 0);
    req_valid = 3'b000;
    tick();
    stall_left = 0;
    resp_due = 1'b0;
    pending = 0;
    rst_n = 1'b1;
    tick();
    exp_rdy.push_back({2'b01, 3'b010});
    exp_rsp.push_back({1'b0, 3'b010});
    req_valid = 3'b010;
    tick();
    check("post_rst_sel_b", mux_sel, 2'b01);
    wait_rdy(rdy_cnt + 1);
    req_valid = 3'b000;
    wait_idle();

    // no response: timeout (feature on) or unbounded WAIT (feature off)
    rsp_en = 1'b0;
    exp_rdy.push_back({2'b10, 3'b100});
`ifdef RV_ARB_TIMEOUT_EN
    exp_rsp.push_back({1'b1, 3'b100});
`endif
    req_valid = 3'b100;
    wait_rdy(rdy_cnt + 1);
    req_valid = 3'b000;
`ifdef RV_ARB_TIMEOUT_EN
    wait_idle();
    stray = 1'b1;
    tick();
    tick();
    stray = 1'b0;
    tick();
    check("late_rsp_busy", busy, 0);
`else
    repeat (300) tick();
    check("no_timeout_busy", busy, 1);
    check("no_timeout_mem_valid", mem_valid, 0);
    rst_n = 1'b0;
    tick();
    pending = 0;
    rst_n = 1'b1;
    tick();
`endif
    rsp_en = 1'b1;
    check("rdy_queue_drained", exp_rdy.size(), 0);
    check("rsp_queue_drained", exp_rsp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
